aer_receiver: RTL and testbench
===============================

AER_RECEIVER -- requirements
Module: aer_receiver

Interface
- REQ-001 SHALL have one clock; reset is asynchronous and active-high.
- REQ-002 SHALL have parameter SETTLE, default 2: cycles a synchronized symbol must be stable before it is accepted (range 1-15).
- REQ-003 SHALL have port clk, input, 1: system clock; all state is updated on its rising edge.
- REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
- REQ-005 SHALL have port bit0, input, 1: dual-rail rail 0 from the upstream AER sender; it is asynchronous to clk.
- REQ-006 SHALL have port bit1, input, 1: dual-rail rail 1 from the upstream AER sender; it is asynchronous to clk.
- REQ-007 SHALL have port ack, output, 1: 4-phase acknowledge returned to the sender.
- REQ-008 SHALL have port ev_valid, output, 1: one-cycle pulse marking a decoded event.
- REQ-009 SHALL have port ev_ch, output, 1: channel of the event, 0=Ch1, 1=Ch2; valid with ev_valid.
- REQ-010 SHALL have port ev_up, output, 1: direction of the event, 1=Up, 0=Down; valid with ev_valid.
- REQ-011 SHALL have port frame_err, output, 1: one-cycle pulse on a protocol violation.
- REQ-012 SHALL have port ev_count, output, 8: count of good events; wraps 255 -> 0.

Function
- REQ-013 SHALL pass bit0 and bit1 each through a 2-flop synchronizer; all logic below uses only the synchronized rails s0 and s1.
- REQ-014 SHALL decode symbols as follows:
  - s0=1, s1=0 is DATA0.
  - s0=0, s1=1 is DATA1.
  - s0=1, s1=1 is CTRL (Fs/Fe).
  - s0=0, s1=0 is NULL.
- REQ-015 SHALL implement the handshake FSM with states IDLE, SETTLE, ACKED.
- REQ-016 SHALL, in IDLE, go to SETTLE and load the settle counter with 0 when {s1,s0} is not NULL.
- REQ-017 SHALL, in SETTLE, restart the settle counter from 0 if {s1,s0} changes.
- REQ-018 SHALL, in SETTLE, return to IDLE with no ack and no error if {s1,s0} returns to NULL.
- REQ-019 SHALL, in SETTLE, accept the symbol when {s1,s0} has been stable for SETTLE consecutive cycles: assert ack on the next edge, present the symbol to the frame parser for exactly one cycle, and go to ACKED.
- REQ-020 SHALL, in ACKED, hold ack=1 until {s1,s0} is NULL for 1 cycle, then drop ack and go to IDLE.
- REQ-021 SHALL ignore rail changes in ACKED other than the return to NULL, so each symbol is accepted exactly once.
- REQ-022 SHALL implement the frame parser with states WAIT_FS, GET_CH, GET_DIR, WAIT_FE; the frame is CTRL, DATAx (channel), DATAx (direction), CTRL.
- REQ-023 SHALL, in WAIT_FS: on CTRL go to GET_CH; on DATA pulse frame_err and stay in WAIT_FS.
- REQ-024 SHALL, in GET_CH: on DATAx latch ch=x and go to GET_DIR; on CTRL pulse frame_err and stay in GET_CH (treated as a new Fs).
- REQ-025 SHALL, in GET_DIR: on DATAx latch up=x and go to WAIT_FE; on CTRL pulse frame_err and go to GET_CH.
- REQ-026 SHALL, in WAIT_FE: on CTRL pulse ev_valid, present ev_ch/ev_up, increment ev_count and go to WAIT_FS; on DATA pulse frame_err, discard the frame and go to WAIT_FS.
- REQ-027 SHALL produce ev_valid in the cycle after the accepting edge of Fe; ack rises on the same edge.
- REQ-028 SHALL acknowledge every accepted symbol, erroneous or not, so the sender never deadlocks.
- REQ-029 SHALL hold ev_ch and ev_up stable between ev_valid pulses.
- REQ-030 SHALL never assert ev_valid and frame_err in the same cycle.

Reset
- REQ-031 SHALL, on reset assertion, immediately force the following, independent of clk: ack=0, ev_valid=0, frame_err=0, ev_ch=0, ev_up=0, ev_count=0, synchronizers=0, handshake FSM=IDLE, parser=WAIT_FS, settle counter=0.
- REQ-032 SHALL, on reset mid-frame, discard the partial frame with no ev_valid and no frame_err.
- REQ-033 SHALL, after reset deassertion, require a NULL symbol before accepting a new one if rails are high; a symbol held across reset is accepted once, after SETTLE cycles.

Verification
- REQ-034 SHALL check frame CTRL, DATA1, DATA1, CTRL with 4-phase sender model: ack cycles 4 times; one ev_valid with ev_ch=1, ev_up=1; ev_count 0 -> 1.
- REQ-035 SHALL check frame CTRL, DATA0, DATA0, CTRL: ev_ch=0, ev_up=0 (Ch1 Down); no frame_err.
- REQ-036 SHALL check a skewed rail arrival with SETTLE=2, bit0 rising 1 cycle before bit1: the symbol is decoded as CTRL only, never as DATA0.
- REQ-037 SHALL check DATA1 first after reset: frame_err pulses once; ack still completes; a following good frame yields ev_valid.
- REQ-038 SHALL check 256 good frames: ev_count wraps to 0 on the 256th ev_valid.
- REQ-039 SHALL check reset asserted during ACKED after CTRL, DATA0: ack drops immediately; no ev_valid; the next full frame decodes correctly.

Source files
------------

// File: rtl/aer_receiver.sv
// Dual-rail AER receiver: synchronizes the rails, settles and 4-phase acknowledges
// each symbol, and parses CTRL/ch/dir/CTRL frames into event pulses.
module aer_receiver #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit0,
  input  logic       bit1,
  output logic       ack,
  output logic       ev_valid,
  output logic       ev_ch,
  output logic       ev_up,
  output logic       frame_err,
  output logic [7:0] ev_count
);

  localparam logic [1:0] SYM_NULL    = 2'b00;
  localparam logic [1:0] SYM_CTRL    = 2'b11;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {HS_IDLE, HS_SETTLE, HS_ACKED} hs_state_t;
  typedef enum logic [1:0] {PS_WAIT_FS, PS_GET_CH, PS_GET_DIR, PS_WAIT_FE} ps_state_t;

  logic [1:0] sync0_r;
  logic [1:0] sync1_r;
  logic [1:0] sym_s;
  logic [1:0] sym_r;
  logic [3:0] cnt_r;
  logic       accept_s;
  logic       ack_r;
  hs_state_t  hs_r;
  ps_state_t  ps_r;
  logic       ch_r;
  logic       up_r;
  logic       ev_valid_r;
  logic       ev_ch_r;
  logic       ev_up_r;
  logic       frame_err_r;
  logic [7:0] ev_count_r;

  // Two-flop synchronizers for each rail
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0_r <= 2'b00;
      sync1_r <= 2'b00;
    end else begin
      sync0_r <= {sync0_r[0], bit0};
      sync1_r <= {sync1_r[0], bit1};
    end
  end

  assign sym_s = {sync1_r[1], sync0_r[1]};

  // Symbol accepted when a non-NULL value has been stable for SETTLE cycles
  always_comb begin
    accept_s = 1'b0;
    if ((hs_r == HS_SETTLE) && (sym_s != SYM_NULL) && (sym_s == sym_r) &&
        (cnt_r == SETTLE_LAST)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Handshake FSM: settle, acknowledge, wait for return to NULL
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_r  <= HS_IDLE;
      cnt_r <= 4'd0;
      sym_r <= SYM_NULL;
      ack_r <= 1'b0;
    end else begin
      case (hs_r)
        HS_IDLE: begin
          if (sym_s != SYM_NULL) begin
            hs_r  <= HS_SETTLE;
            cnt_r <= 4'd0;
            sym_r <= sym_s;
          end
        end
        HS_SETTLE: begin
          if (sym_s == SYM_NULL) begin
            hs_r  <= HS_IDLE;
            cnt_r <= 4'd0;
          end else if (sym_s != sym_r) begin
            sym_r <= sym_s;
            cnt_r <= 4'd0;
          end else if (accept_s) begin
            ack_r <= 1'b1;
            hs_r  <= HS_ACKED;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        HS_ACKED: begin
          // Only the return to NULL matters here; each symbol is taken once
          if (sym_s == SYM_NULL) begin
            ack_r <= 1'b0;
            hs_r  <= HS_IDLE;
          end
        end
        default: begin
          hs_r  <= HS_IDLE;
          ack_r <= 1'b0;
        end
      endcase
    end
  end

  // Frame parser: CTRL, channel, direction, CTRL
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_r        <= PS_WAIT_FS;
      ch_r        <= 1'b0;
      up_r        <= 1'b0;
      ev_valid_r  <= 1'b0;
      ev_ch_r     <= 1'b0;
      ev_up_r     <= 1'b0;
      frame_err_r <= 1'b0;
      ev_count_r  <= 8'd0;
    end else begin
      ev_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      if (accept_s) begin
        case (ps_r)
          PS_WAIT_FS: begin
            if (sym_s == SYM_CTRL) begin
              ps_r <= PS_GET_CH;
            end else begin
              frame_err_r <= 1'b1;
            end
          end
          PS_GET_CH: begin
            if (sym_s == SYM_CTRL) begin
              frame_err_r <= 1'b1;
            end else begin
              ch_r <= sym_s[1];
              ps_r <= PS_GET_DIR;
            end
          end
          PS_GET_DIR: begin
            if (sym_s == SYM_CTRL) begin
              frame_err_r <= 1'b1;
              ps_r        <= PS_GET_CH;
            end else begin
              up_r <= sym_s[1];
              ps_r <= PS_WAIT_FE;
            end
          end
          PS_WAIT_FE: begin
            if (sym_s == SYM_CTRL) begin
              ev_valid_r <= 1'b1;
              ev_ch_r    <= ch_r;
              ev_up_r    <= up_r;
              ev_count_r <= ev_count_r + 8'd1;
            end else begin
              frame_err_r <= 1'b1;
            end
            ps_r <= PS_WAIT_FS;
          end
          default: ps_r <= PS_WAIT_FS;
        endcase
      end
    end
  end

  assign ack       = ack_r;
  assign ev_valid  = ev_valid_r;
  assign ev_ch     = ev_ch_r;
  assign ev_up     = ev_up_r;
  assign frame_err = frame_err_r;
  assign ev_count  = ev_count_r;

endmodule

// File: tb/tb_aer_receiver.sv
// Directed bench for aer_receiver: 4-phase sender model, event/error monitors.
module tb_aer_receiver;

  logic       clk;
  logic       reset;
  logic       bit0;
  logic       bit1;
  logic       ack;
  logic       ev_valid;
  logic       ev_ch;
  logic       ev_up;
  logic       frame_err;
  logic [7:0] ev_count;

  int n_checks = 0;
  int n_fail   = 0;
  int ev_n     = 0;
  int err_n    = 0;
  int both_n   = 0;
  int ack_rise = 0;
  logic ack_q  = 1'b0;
  int ev0, err0, ack0;

  aer_receiver #(.SETTLE(2)) dut (
    .clk(clk), .reset(reset), .bit0(bit0), .bit1(bit1), .ack(ack),
    .ev_valid(ev_valid), .ev_ch(ev_ch), .ev_up(ev_up),
    .frame_err(frame_err), .ev_count(ev_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitors sample on the falling edge, away from DUT updates
  always @(negedge clk) begin
    if (ev_valid === 1'b1) ev_n++;
    if (frame_err === 1'b1) err_n++;
    if ((ev_valid === 1'b1) && (frame_err === 1'b1)) both_n++;
    if ((ack === 1'b1) && (ack_q === 1'b0)) ack_rise++;
    ack_q = ack;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input logic lvl, input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ack === lvl) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic send_sym(input logic b1, input logic b0);
    @(negedge clk);
    bit1 = b1;
    bit0 = b0;
    wait_ack(1'b1, "ack_rise_timeout");
    bit1 = 1'b0;
    bit0 = 1'b0;
    wait_ack(1'b0, "ack_fall_timeout");
  endtask

  task automatic send_data(input logic x);
    send_sym(x, ~x);
  endtask

  task automatic send_frame(input logic c, input logic u);
    send_sym(1'b1, 1'b1);
    send_data(c);
    send_data(u);
    send_sym(1'b1, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bit0  = 1'b0;
    bit1  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic snap();
    ev0  = ev_n;
    err0 = err_n;
    ack0 = ack_rise;
  endtask

  initial begin
    reset = 1'b1;
    bit0  = 1'b0;
    bit1  = 1'b0;
    #12;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_ev_valid", {31'd0, ev_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_ev_ch", {31'd0, ev_ch}, 32'd0);
    check("rst_ev_up", {31'd0, ev_up}, 32'd0);
    check("rst_ev_count", {24'd0, ev_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // CTRL, DATA1, DATA1, CTRL -> Ch2 Up
    snap();
    send_frame(1'b1, 1'b1);
    check("f1_ack_cycles", ack_rise - ack0, 32'd4);
    check("f1_events", ev_n - ev0, 32'd1);
    check("f1_ev_ch", {31'd0, ev_ch}, 32'd1);
    check("f1_ev_up", {31'd0, ev_up}, 32'd1);
    check("f1_count", {24'd0, ev_count}, 32'd1);
    check("f1_err", err_n - err0, 32'd0);

    // CTRL, DATA0, DATA0, CTRL -> Ch1 Down
    snap();
    send_frame(1'b0, 1'b0);
    check("f2_events", ev_n - ev0, 32'd1);
    check("f2_ev_ch", {31'd0, ev_ch}, 32'd0);
    check("f2_ev_up", {31'd0, ev_up}, 32'd0);
    check("f2_err", err_n - err0, 32'd0);
    check("f2_count", {24'd0, ev_count}, 32'd2);

    // Skewed Fs: bit0 one cycle ahead of bit1 must decode as CTRL only
    snap();
    @(negedge clk);
    bit0 = 1'b1;
    @(negedge clk);
    bit1 = 1'b1;
    wait_ack(1'b1, "skew_ack_rise_timeout");
    bit0 = 1'b0;
    bit1 = 1'b0;
    wait_ack(1'b0, "skew_ack_fall_timeout");
    check("skew_ack_once", ack_rise - ack0, 32'd1);
    check("skew_no_err", err_n - err0, 32'd0);
    send_data(1'b1);
    send_data(1'b0);
    send_sym(1'b1, 1'b1);
    repeat (2) @(negedge clk);
    check("skew_events", ev_n - ev0, 32'd1);
    check("skew_ev_ch", {31'd0, ev_ch}, 32'd1);
    check("skew_ev_up", {31'd0, ev_up}, 32'd0);
    check("skew_count", {24'd0, ev_count}, 32'd3);

    // DATA1 first after reset: one frame_err, ack completes, next frame good
    do_reset();
    check("r2_count", {24'd0, ev_count}, 32'd0);
    snap();
    send_data(1'b1);
    repeat (2) @(negedge clk);
    check("d1first_err", err_n - err0, 32'd1);
    check("d1first_ack", ack_rise - ack0, 32'd1);
    send_frame(1'b0, 1'b1);
    check("d1first_events", ev_n - ev0, 32'd1);
    check("d1first_ev_ch", {31'd0, ev_ch}, 32'd0);
    check("d1first_ev_up", {31'd0, ev_up}, 32'd1);
    check("d1first_count", {24'd0, ev_count}, 32'd1);

    // 256 good frames: count wraps to 0 on the 256th event
    do_reset();
    snap();
    for (int i = 0; i < 255; i++) send_frame(i[0], i[1]);
    check("wrap_255", {24'd0, ev_count}, 32'd255);
    send_frame(1'b1, 1'b0);
    check("wrap_0", {24'd0, ev_count}, 32'd0);
    check("wrap_events", ev_n - ev0, 32'd256);
    check("wrap_err", err_n - err0, 32'd0);

    // Reset while in ACKED after CTRL, DATA0
    snap();
    send_sym(1'b1, 1'b1);
    @(negedge clk);
    bit1 = 1'b0;
    bit0 = 1'b1;
    wait_ack(1'b1, "acked_ack_rise_timeout");
    #2;
    reset = 1'b1;
    #1;
    check("acked_rst_ack", {31'd0, ack}, 32'd0);
    bit0 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("acked_rst_no_ev", ev_n - ev0, 32'd0);
    check("acked_rst_no_err", err_n - err0, 32'd0);
    send_frame(1'b1, 1'b1);
    check("post_rst_events", ev_n - ev0, 32'd1);
    check("post_rst_ev_ch", {31'd0, ev_ch}, 32'd1);
    check("post_rst_ev_up", {31'd0, ev_up}, 32'd1);
    check("post_rst_count", {24'd0, ev_count}, 32'd1);
    check("post_rst_err", err_n - err0, 32'd0);

    check("never_ev_and_err", both_n, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
